// File: rtl/bram1_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram1_arb_pkg
// Brief    : Shared types for the BRAM1 round-robin arbiter (owner id, tag).
// Revision : 1.0 - initial release
// ============================================================================
package bram1_arb_pkg;

  typedef enum logic {
    OWNER0 = 1'b0,
    OWNER1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

  localparam int STAT_WIDTH = 32;

endpackage
`default_nettype wire

// File: rtl/bram1_arb_rsp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram1_arb_rsp_pipe
// Brief    : Read-response tag shift register, depth 1+PIPELINED, sync clear.
// Revision : 1.0 - initial release
// ============================================================================
module bram1_arb_rsp_pipe
  import bram1_arb_pkg::*;
#(
  parameter int PIPELINED = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  localparam int DEPTH = 1 + PIPELINED;

  tag_t stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/bram1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram1_arbiter
// Brief    : Two-requester round-robin arbiter in front of one BRAM1 port.
//            Define BRAM1_ARB_STATS_EN to add grant/conflict statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module bram1_arbiter
  import bram1_arb_pkg::*;
#(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic                  WE0,
  input  logic                  WE1,
  input  logic [ADDR_WIDTH-1:0] ADDR0,
  input  logic [ADDR_WIDTH-1:0] ADDR1,
  input  logic [DATA_WIDTH-1:0] DI0,
  input  logic [DATA_WIDTH-1:0] DI1,
  output logic                  GNT0,
  output logic                  GNT1,
  output logic                  RVALID0,
  output logic                  RVALID1,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
`ifdef BRAM1_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] STAT_GNT0,
  output logic [STAT_WIDTH-1:0] STAT_GNT1,
  output logic [STAT_WIDTH-1:0] STAT_CONFLICT
`endif
);

  owner_t last_gnt_q, last_gnt_d;
  logic   w_gnt0, w_gnt1;
  tag_t   w_tag_in, w_tag_out;

  // Reset value OWNER1 hands the first conflict to requester 0.
  assign w_gnt0 = REQ0 & (~REQ1 | (last_gnt_q != OWNER0)) & ~RST;
  assign w_gnt1 = REQ1 & (~REQ0 | (last_gnt_q != OWNER1)) & ~RST;

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (w_gnt0)      last_gnt_d = OWNER0;
    else if (w_gnt1) last_gnt_d = OWNER1;
  end

  always_ff @(posedge CLK) begin
    if (RST) last_gnt_q <= OWNER1;
    else     last_gnt_q <= last_gnt_d;
  end

  assign GNT0    = w_gnt0;
  assign GNT1    = w_gnt1;
  assign BRAM_EN = w_gnt0 | w_gnt1;

  always_comb begin
    BRAM_WE   = 1'b0;
    BRAM_ADDR = '0;
    BRAM_DI   = '0;
    if (w_gnt0) begin
      BRAM_WE   = WE0;
      BRAM_ADDR = ADDR0;
      BRAM_DI   = DI0;
    end else if (w_gnt1) begin
      BRAM_WE   = WE1;
      BRAM_ADDR = ADDR1;
      BRAM_DI   = DI1;
    end
  end

  assign w_tag_in.valid = (w_gnt0 & ~WE0) | (w_gnt1 & ~WE1);
  assign w_tag_in.owner = w_gnt1 ? OWNER1 : OWNER0;

  bram1_arb_rsp_pipe #(
    .PIPELINED (PIPELINED)
  ) u_rsp_pipe (
    .clk_i (CLK),
    .rst_i (RST),
    .tag_i (w_tag_in),
    .tag_o (w_tag_out)
  );

  // Gating by RST drops a response that would surface in the reset cycle itself.
  assign RVALID0 = w_tag_out.valid & (w_tag_out.owner == OWNER0) & ~RST;
  assign RVALID1 = w_tag_out.valid & (w_tag_out.owner == OWNER1) & ~RST;
  assign RDATA   = BRAM_DO;

`ifdef BRAM1_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_gnt0_q, stat_gnt1_q, stat_conflict_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stat_gnt0_q     <= '0;
      stat_gnt1_q     <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (w_gnt0 && (stat_gnt0_q != '1))         stat_gnt0_q     <= stat_gnt0_q + 1'b1;
      if (w_gnt1 && (stat_gnt1_q != '1))         stat_gnt1_q     <= stat_gnt1_q + 1'b1;
      if (REQ0 && REQ1 && (stat_conflict_q != '1)) stat_conflict_q <= stat_conflict_q + 1'b1;
    end
  end

  assign STAT_GNT0     = stat_gnt0_q;
  assign STAT_GNT1     = stat_gnt1_q;
  assign STAT_CONFLICT = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram1_arbiter
// Brief    : Directed + random bench for bram1_arbiter with a BRAM1 model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram1_arbiter;

  localparam int PIPE = 1;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] di0, di1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di, bram_do;
`ifdef BRAM1_ARB_STATS_EN
  logic [31:0]   stat_gnt0, stat_gnt1, stat_conflict;
`endif

  always #5 clk = ~clk;

  bram1_arbiter #(
    .PIPELINED  (PIPE),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .REQ0      (req0),
    .REQ1      (req1),
    .WE0       (we0),
    .WE1       (we1),
    .ADDR0     (addr0),
    .ADDR1     (addr1),
    .DI0       (di0),
    .DI1       (di1),
    .GNT0      (gnt0),
    .GNT1      (gnt1),
    .RVALID0   (rvalid0),
    .RVALID1   (rvalid1),
    .RDATA     (rdata),
    .BRAM_EN   (bram_en),
    .BRAM_WE   (bram_we),
    .BRAM_ADDR (bram_addr),
    .BRAM_DI   (bram_di),
    .BRAM_DO   (bram_do)
`ifdef BRAM1_ARB_STATS_EN
    ,
    .STAT_GNT0     (stat_gnt0),
    .STAT_GNT1     (stat_gnt1),
    .STAT_CONFLICT (stat_conflict)
`endif
  );

  // Write-first single-port BRAM1 with optional output register.
  logic [DW-1:0] mem [16];
  logic [DW-1:0] do_r, do_p;
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_di;
        do_r           <= bram_di;
      end else begin
        do_r <= mem[bram_addr];
      end
    end
  end
  always @(posedge clk) do_p <= do_r;
  assign bram_do = (PIPE != 0) ? do_p : do_r;

  // Reference model state
  int            n_cmp  = 0;
  int            n_fail = 0;
  int            cyc    = 0;
  int            pri    = 0;        // requester that wins the next conflict
  logic [DW-1:0] ref_mem [16];
  logic          exp_v [8];
  int            exp_o [8];
  logic [DW-1:0] exp_d [8];
  logic          got0, got1;
  int            cnt_g0, cnt_g1, cnt_cf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set0(input logic r, input logic w, input int a, input int d);
    req0 = r; we0 = w; addr0 = AW'(a); di0 = DW'(d);
  endtask

  task automatic set1(input logic r, input logic w, input int a, input int d);
    req1 = r; we1 = w; addr1 = AW'(a); di1 = DW'(d);
  endtask

  task automatic cycle();
    logic          g0, g1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            s, ns;
    @(negedge clk);
    s = cyc % 8;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      for (int i = 0; i < 8; i++) exp_v[i] = 1'b0;
    end else if (req0 && req1) begin
      g0 = (pri == 0);
      g1 = (pri == 1);
    end else begin
      g0 = req0;
      g1 = req1;
    end

    chk("rvalid0", 32'(rvalid0), 32'(exp_v[s] && exp_o[s] == 0));
    chk("rvalid1", 32'(rvalid1), 32'(exp_v[s] && exp_o[s] == 1));
    if (exp_v[s]) chk("rdata", 32'(rdata), 32'(exp_d[s]));
    exp_v[s] = 1'b0;

    w = g0 ? we0   : (g1 ? we1   : 1'b0);
    a = g0 ? addr0 : (g1 ? addr1 : '0);
    d = g0 ? di0   : (g1 ? di1   : '0);
    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    chk("bram_en", 32'(bram_en), 32'(g0 | g1));
    chk("bram_we", 32'(bram_we), 32'(w));
    chk("bram_addr", 32'(bram_addr), 32'(a));
    chk("bram_di", 32'(bram_di), 32'(d));

`ifdef BRAM1_ARB_STATS_EN
    chk("stat_gnt0", stat_gnt0, 32'(cnt_g0));
    chk("stat_gnt1", stat_gnt1, 32'(cnt_g1));
    chk("stat_conflict", stat_conflict, 32'(cnt_cf));
`endif
    if (rst) begin
      pri = 0;
      cnt_g0 = 0; cnt_g1 = 0; cnt_cf = 0;
    end else begin
      if (g0) cnt_g0++;
      if (g1) cnt_g1++;
      if (req0 && req1) cnt_cf++;
    end

    if (g0 || g1) begin
      pri = g0 ? 1 : 0;
      if (w) begin
        ref_mem[a] = d;
      end else begin
        ns = (cyc + 1 + PIPE) % 8;
        exp_v[ns] = 1'b1;
        exp_o[ns] = g1 ? 1 : 0;
        exp_d[ns] = ref_mem[a];
      end
    end
    got0 = g0;
    got1 = g1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin exp_v[i] = 1'b0; exp_o[i] = 0; exp_d[i] = '0; end
    cnt_g0 = 0; cnt_g1 = 0; cnt_cf = 0;
    got0 = 1'b0; got1 = 1'b0;
    rst = 1'b1;
    set0(1, 1, 7, 8'h11);
    set1(1, 1, 9, 8'h22);
    cycle();
    cycle();
    rst = 1'b0;
    set1(0, 0, 0, 0);

    // Lone write of 0x5A to address 3, then idle long enough to see any stray RVALID
    set0(1, 1, 3, 8'h5A);
    cycle();
    set0(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Requester 1 reads it back
    set1(1, 0, 3, 0);
    cycle();
    set1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Preload every address through requester 0
    for (int i = 0; i < 16; i++) begin
      set0(1, 1, i, $urandom_range(0, 255));
      cycle();
    end
    set0(0, 0, 0, 0);
    cycle();

    // Six cycles of conflicting reads straight after reset
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set0(1, 0, i, 0);
      set1(1, 0, i + 8, 0);
      cycle();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Back-to-back reads from requester 0
    for (int i = 1; i <= 3; i++) begin
      set0(1, 0, i, 0);
      cycle();
    end
    set0(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Read in flight killed by a one-cycle reset, then a conflict
    set1(1, 0, 5, 0);
    cycle();
    set1(0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set0(1, 0, 6, 0);
    set1(1, 0, 7, 0);
    cycle();
    set0(0, 0, 0, 0);
    cycle();
    set1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

    // Random traffic; a request is held until the model says it was granted
    for (int k = 0; k < 400; k++) begin
      if (!req0 || got0)
        set0($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 255));
      if (!req1 || got1)
        set1($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 15), $urandom_range(0, 255));
      rst = ($urandom_range(0, 59) == 0);
      cycle();
    end
    rst = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();

`ifdef BRAM1_ARB_STATS_EN
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set0(1, 0, i, 0);
      set1(1, 0, 15 - i, 0);
      cycle();
    end
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    chk("stat_conflict_10", stat_conflict, 32'd10);
    chk("stat_gnt_sum_10", stat_gnt0 + stat_gnt1, 32'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("stat_gnt0_clr", stat_gnt0, 32'd0);
    chk("stat_gnt1_clr", stat_gnt1, 32'd0);
    chk("stat_conflict_clr", stat_conflict, 32'd0);
    for (int i = 0; i < 3; i++) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
